gcd_arbiter: RTL

GCD_ARBITER -- requirements
Module: gcd_arbiter

---
 rtl/gcd_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one GCD core among NREQ requesters.
// Latency: grant to response = 3 + cycles from first WAIT cycle to core done-rise.
// Backpressure: one operation in flight; other requesters hold valid until granted.
//
// Ports:
//   clk, resetb        rising-edge clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake; req_ready is a one-hot grant
//   req_u/req_v        packed operands, requester i at [i*W +: W]
//   rsp_valid          one-hot, one-cycle result strobe to the owning requester
//   rsp_res/rsp_err    result and timeout flag, valid with rsp_valid
//   core_ld            one-cycle load pulse to the core
//   core_u/core_v      operands, held from LOAD until the next grant
//   core_res/core_done core result and level completion (rising edge counts)
//
// Optional feature: define GCD_ARB_TIMEOUT_EN to abandon a WAIT after TMO
// cycles without a done-rise, answering with rsp_err=1 and rsp_res=0.
module gcd_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int TMO  = 255
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_u,
    input  logic [NREQ*W-1:0] req_v,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_res,
    output logic              rsp_err,
    output logic              core_ld,
    output logic [W-1:0]      core_u,
    output logic [W-1:0]      core_v,
    input  logic [W-1:0]      core_res,
    input  logic              core_done
);
    localparam int IW = $clog2(NREQ);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] owner;
    logic          done_q;
    logic          done_rise;

    logic [IW-1:0] rr_win;
    logic          rr_any;
    logic [IW:0]   rr_sum;

    // done_q follows core_done every cycle, so a level that was already high
    // when WAIT is entered never looks like a rise.
    assign done_rise = core_done & ~done_q;

    // Search ptr+1, ptr+2, ... (mod NREQ); walking from the far end and
    // overwriting leaves the nearest active requester as the winner.
    always_comb begin
        rr_win = '0;
        rr_any = 1'b0;
        rr_sum = '0;
        for (int s = NREQ; s >= 1; s--) begin
            rr_sum = {1'b0, ptr} + (IW+1)'(s);
            if (rr_sum >= (IW+1)'(NREQ)) begin
                rr_sum = rr_sum - (IW+1)'(NREQ);
            end
            if (req_valid[rr_sum[IW-1:0]]) begin
                rr_win = rr_sum[IW-1:0];
                rr_any = 1'b1;
            end
        end
    end

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Counts WAIT cycles; the TMO-th WAIT cycle without a rise expires.
    assign tmo_hit = (state == S_WAIT) && (tmo_cnt == CW'(TMO - 1));

    always_ff @(posedge clk) begin
        if (resetb) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO;
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (resetb) begin
            state     <= S_IDLE;
            ptr       <= IW'(NREQ - 1);
            win       <= '0;
            owner     <= '0;
            done_q    <= 1'b0;
            req_ready <= '0;
            rsp_valid <= '0;
            core_ld   <= 1'b0;
            rsp_res   <= '0;
            core_u    <= '0;
            core_v    <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            done_q    <= core_done;
            // Pulse outputs default low; each state raises its own for one cycle.
            req_ready <= '0;
            rsp_valid <= '0;
            core_ld   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rr_any) begin
                        win       <= rr_win;
                        req_ready <= NREQ'(1) << rr_win;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Handshake completes only if the winner still holds valid;
                    // otherwise ptr is left alone so the rotation is unaffected.
                    if (req_valid[win]) begin
                        core_u  <= req_u[win*W +: W];
                        core_v  <= req_v[win*W +: W];
                        owner   <= win;
                        core_ld <= 1'b1;
                        state   <= S_LOAD;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done-rise takes priority over a simultaneous expiry.
                    if (done_rise) begin
                        rsp_res   <= core_res;
                        rsp_valid <= NREQ'(1) << owner;
                        state     <= S_RESP;
`ifdef GCD_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_res   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NREQ'(1) << owner;
                        state     <= S_RESP;
`endif
                    end
                end
                S_RESP: begin
                    ptr   <= owner;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
